// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants, FSM state type and the flip-address helper
// for the sprite ROM reader and its output FIFO.
//
// Contents:
//   SPR_W          pixels per sprite row (and rows per sprite)
//   DATA_W         pixel / ROM word width
//   ADDR_W         ROM word address width, log2(SPR_W*SPR_W)
//   ROW_W          width of a row or column index, log2(SPR_W)
//   ROM_RD_LATENCY fixed read latency of the sprite ROM slave, in cycles
//   state_t        reader FSM states
//   flip_addr()    ROM word address of (row, col) under optional flips
package sprite_pkg;

    localparam int SPR_W          = 16;
    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 8;
    localparam int ROW_W          = $clog2(SPR_W);
    localparam int ROM_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Row-major sprite image: address = row * SPR_W + col. A flip mirrors the
    // index inside 0..SPR_W-1, so the result always stays inside the image.
    function automatic logic [ADDR_W-1:0] flip_addr(
        input logic [ROW_W-1:0] row,
        input logic [ROW_W-1:0] col,
        input logic             hflip,
        input logic             vflip
    );
        logic [ROW_W-1:0] r;
        logic [ROW_W-1:0] c;
        r = vflip ? (ROW_W'(SPR_W - 1) - row) : row;
        c = hflip ? (ROW_W'(SPR_W - 1) - col) : col;
        return ADDR_W'({r, c});
    endfunction

endpackage

// File: rtl/sprite_fifo.sv
// sprite_fifo: small synchronous FIFO carrying pixel words plus a last tag.
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset; flushes pointers, count, storage
//   push       write push_data at the tail this cycle
//   push_data  WIDTH-bit entry
//   pop        retire the head entry this cycle
//   head       current head entry (meaningful when count != 0)
//   count      number of valid entries, 0..DEPTH
//
// The caller guarantees push never happens when full and pop never happens
// when empty; the FIFO does not guard against either.
module sprite_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sprite_rom_reader.sv
// sprite_rom_reader: Avalon-MM read master that fetches one 16-pixel row of a
// 16x16 sprite from the sprite ROM (applying optional horizontal/vertical
// flips by address arithmetic) and streams the pixels downstream.
//
// Ports:
//   clk, reset_n        system clock, synchronous active-low reset
//   req_valid/req_ready row fetch request handshake; ready only in IDLE
//   req_row             sprite row 0..15
//   req_hflip/req_vflip reverse column order / use row 15-req_row
//   rom_*               Avalon-MM master to the ROM; 1-cycle read latency
//   pix_valid/pix_ready pixel stream handshake
//   pix_data, pix_last  pixel word, high on the 16th pixel of the row
//   busy                high in FETCH or DRAIN
//   dbg_state           current FSM state, for observation only
//
// Handshakes (req_* and pix_*): a transfer happens on a rising edge where
// valid and ready are both high; the producer holds valid and its payload
// stable until that edge, and valid never depends on ready.
module sprite_rom_reader
    import sprite_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ROW_W-1:0]  req_row,
    input  logic              req_hflip,
    input  logic              req_vflip,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_chipselect,
    output logic              rom_clken,
    output logic              rom_write,
    output logic [1:0]        rom_byteenable,
    input  logic [DATA_W-1:0] rom_readdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_last,
    output logic              busy,
    output state_t            dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t state_q;
    state_t state_d;

    logic              out_of_reset;   // low for the cycle following a reset edge
    logic              inflight;       // ROM returns read data this cycle
    logic              cs_last;        // read issued this cycle is the row's last
    logic              inflight_last;  // returning word is the row's last
    logic [ROW_W:0]    issue_cnt;      // reads issued so far; also next column
    logic [ROW_W-1:0]  row_q;
    logic              hflip_q;
    logic              vflip_q;

    logic              accept;
    logic              issue;
    logic              issue_last;
    logic              credit_ok;
    logic              pop;
    logic [ADDR_W-1:0] issue_addr;
    logic [CW+1:0]     occupancy;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W:0]   fifo_head;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)               state_d = FETCH;
            FETCH:   if (issue && issue_last)  state_d = DRAIN;
            DRAIN:   if (pop && pix_last)      state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // ---------------- output / issue logic ----------------
    // The read decision is made one cycle ahead and registered into
    // rom_chipselect/rom_address. Every word already committed but not yet
    // popped (FIFO entries, the read on the bus, the word returning) holds a
    // credit; a pop this cycle releases one, so reads resume right after it.
    always_comb begin
        req_ready  = (state_q == IDLE) && out_of_reset;
        busy       = (state_q == FETCH) || (state_q == DRAIN);
        pix_valid  = (fifo_count != '0);
        pix_last   = pix_valid & fifo_head[DATA_W];
        pix_data   = pix_valid ? fifo_head[DATA_W-1:0] : '0;
        pop        = pix_valid & pix_ready;

        occupancy  = (CW+2)'(fifo_count) + (CW+2)'(rom_chipselect) + (CW+2)'(inflight);
        credit_ok  = occupancy < ((CW+2)'(FIFO_DEPTH) + (CW+2)'(pop));

        accept     = req_ready && req_valid;
        issue_last = (state_q == FETCH) && (issue_cnt == (ROW_W+1)'(SPR_W - 1));
        issue      = accept ||
                     ((state_q == FETCH) && (issue_cnt < (ROW_W+1)'(SPR_W)) && credit_ok);
        issue_addr = accept ? flip_addr(req_row, '0, req_hflip, req_vflip)
                            : flip_addr(row_q, issue_cnt[ROW_W-1:0], hflip_q, vflip_q);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_of_reset   <= 1'b0;
            rom_chipselect <= 1'b0;
            rom_address    <= '0;
            inflight       <= 1'b0;
            cs_last        <= 1'b0;
            inflight_last  <= 1'b0;
            issue_cnt      <= '0;
            row_q          <= '0;
            hflip_q        <= 1'b0;
            vflip_q        <= 1'b0;
        end else begin
            out_of_reset   <= 1'b1;
            rom_chipselect <= issue;
            if (issue) begin
                rom_address <= issue_addr;
            end
            inflight       <= rom_chipselect;
            cs_last        <= issue & issue_last;
            inflight_last  <= cs_last;
            if (accept) begin
                row_q     <= req_row;
                hflip_q   <= req_hflip;
                vflip_q   <= req_vflip;
                issue_cnt <= (ROW_W+1)'(1);
            end else if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
        end
    end

    assign rom_clken      = out_of_reset;
    assign rom_write      = 1'b0;
    assign rom_byteenable = 2'b11;
    assign dbg_state      = state_q;

    // The returning word is written at the end of the cycle after its read.
    sprite_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data ({inflight_last, rom_readdata}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sprite_rom_reader.sv
// Testbench for sprite_rom_reader: a ROM model holding word = address, a
// scoreboard of expected {last, pixel} entries, and one task per scenario.
// Cycle index k below counts sample points taken 1 time unit after each
// rising edge, with k=0 right after the request-accepting edge E0.
module tb_sprite_rom_reader;
    import sprite_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ROW_W-1:0]  req_row = '0;
    logic              req_hflip = 1'b0;
    logic              req_vflip = 1'b0;
    logic [ADDR_W-1:0] rom_address;
    logic              rom_chipselect;
    logic              rom_clken;
    logic              rom_write;
    logic [1:0]        rom_byteenable;
    logic [DATA_W-1:0] rom_readdata;
    logic              pix_valid;
    logic              pix_ready = 1'b0;
    logic [DATA_W-1:0] pix_data;
    logic              pix_last;
    logic              busy;
    state_t            dbg_state;

    int errors = 0;
    int checks = 0;
    int pop_cnt = 0;
    int cs_total = 0;
    int pop_total = 0;
    logic [DATA_W:0] exp_q[$];
    logic            stall_prev = 1'b0;
    logic [DATA_W:0] stall_word = '0;

    always #5 clk = ~clk;

    sprite_rom_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_row        (req_row),
        .req_hflip      (req_hflip),
        .req_vflip      (req_vflip),
        .rom_address    (rom_address),
        .rom_chipselect (rom_chipselect),
        .rom_clken      (rom_clken),
        .rom_write      (rom_write),
        .rom_byteenable (rom_byteenable),
        .rom_readdata   (rom_readdata),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_data       (pix_data),
        .pix_last       (pix_last),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // ROM: word = address, one cycle after chipselect; noise otherwise.
    always @(posedge clk) begin
        rom_readdata <= rom_chipselect ? DATA_W'(rom_address) : DATA_W'($urandom);
    end

    function automatic logic [DATA_W-1:0] model_word(input int row, input int col,
                                                     input bit h, input bit v);
        int r;
        int c;
        r = v ? 15 - row : row;
        c = h ? 15 - col : col;
        return DATA_W'(r * 16 + c);
    endfunction

    // Scoreboard, output-hold and credit monitors, sampled on the falling edge.
    always @(negedge clk) begin
        logic [DATA_W:0] exp_w;
        if (!reset_n) begin
            cs_total   = 0;
            pop_total  = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (pix_valid !== 1'b1 || {pix_last, pix_data} !== stall_word) begin
                    errors++;
                    $display("FAIL hold: valid=%b word=%h, required valid=1 word=%h",
                             pix_valid, {pix_last, pix_data}, stall_word);
                end
            end
            stall_prev = pix_valid && !pix_ready;
            stall_word = {pix_last, pix_data};
            if (rom_chipselect === 1'b1) begin
                cs_total++;
                checks++;
                if (cs_total - pop_total > DEPTH) begin
                    errors++;
                    $display("FAIL credit: outstanding=%0d, required <= %0d",
                             cs_total - pop_total, DEPTH);
                end
            end
            if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel: got %h, required no pixel",
                             {pix_last, pix_data});
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({pix_last, pix_data} !== exp_w) begin
                        errors++;
                        $display("FAIL pixel: got last=%b data=%h, required last=%b data=%h",
                                 pix_last, pix_data, exp_w[DATA_W], exp_w[DATA_W-1:0]);
                    end
                end
                pop_total++;
                pop_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for req_ready, presents one request for a single edge and loads
    // the scoreboard with that row's expected pixels.
    task automatic send_req(input int row, input bit h, input bit v, output bit ok);
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_wait: req_ready=%b after %0d cycles, required 1", req_ready, n);
            ok = 1'b0;
            return;
        end
        req_valid = 1'b1;
        req_row   = ROW_W'(row);
        req_hflip = h;
        req_vflip = v;
        for (int c = 0; c < 16; c++) begin
            exp_q.push_back({c == 15, model_word(row, c, h, v)});
        end
        tick();
        req_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        pix_ready = 1'b0;
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({rom_chipselect, rom_address, rom_clken, pix_valid, pix_last, pix_data,
             busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cs=%b addr=%h clken=%b pv=%b last=%b data=%h busy=%b rr=%b, required all 0",
                     rom_chipselect, rom_address, rom_clken, pix_valid, pix_last, pix_data,
                     busy, req_ready);
        end
        checks++;
        if ({rom_write, rom_byteenable} !== 3'b011) begin
            errors++;
            $display("FAIL rom_constants: write=%b byteenable=%b, required 0 11",
                     rom_write, rom_byteenable);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if ({req_ready, rom_clken, busy, pix_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release: rr=%b clken=%b busy=%b pv=%b, required 1 1 0 0",
                     req_ready, rom_clken, busy, pix_valid);
        end
    endtask

    // Unstalled row: chipselect k=0..15, pix_valid k=2..17, pix_last at k=17,
    // req_ready back from k=18.
    task automatic test_row(input int row, input bit h, input bit v);
        logic [24:0] cs_h;
        logic [24:0] pv_h;
        logic [24:0] last_h;
        logic [24:0] rr_h;
        bit ok;
        pix_ready = 1'b1;
        send_req(row, h, v, ok);
        if (ok) begin
            for (int k = 0; k < 25; k++) begin
                cs_h[k]   = rom_chipselect;
                pv_h[k]   = pix_valid;
                last_h[k] = pix_valid & pix_last;
                rr_h[k]   = req_ready;
                tick();
            end
            checks++;
            if (cs_h !== 25'h000FFFF) begin
                errors++;
                $display("FAIL row%0d_h%0d_v%0d_chipselect: got %h, required 000ffff", row, h, v, cs_h);
            end
            checks++;
            if (pv_h !== 25'h003FFFC) begin
                errors++;
                $display("FAIL row%0d_h%0d_v%0d_pix_valid: got %h, required 003fffc", row, h, v, pv_h);
            end
            checks++;
            if (last_h !== 25'h0020000) begin
                errors++;
                $display("FAIL row%0d_h%0d_v%0d_pix_last: got %h, required 0020000", row, h, v, last_h);
            end
            checks++;
            if (rr_h !== 25'h1FC0000) begin
                errors++;
                $display("FAIL row%0d_h%0d_v%0d_req_ready: got %h, required 1fc0000", row, h, v, rr_h);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL row%0d_h%0d_v%0d_drained: %0d pixels left, required 0",
                     row, h, v, exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        int n_cs = 0;
        int n = 0;
        pix_ready = 1'b0;
        send_req(0, 1'b0, 1'b0, ok);
        for (int k = 0; k < 10; k++) begin
            if (rom_chipselect === 1'b1) n_cs++;
            tick();
        end
        checks++;
        if (n_cs != DEPTH) begin
            errors++;
            $display("FAIL stall_reads: got %0d chipselects, required %0d", n_cs, DEPTH);
        end
        checks++;
        if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_valid: pix_valid=%b, required 1", pix_valid);
        end
        pix_ready = 1'b1;
        while (!(req_ready === 1'b1 && exp_q.size() == 0) && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_resume: req_ready=%b left=%0d, required 1 and 0",
                     req_ready, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        bit h;
        bit v;
        int n;
        for (int r = 0; r < 16; r++) begin
            h = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            send_req(r, h, v, ok);
            n = 0;
            while (!(req_ready === 1'b1 && exp_q.size() == 0) && n < 400) begin
                pix_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            checks++;
            if (req_ready !== 1'b1 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL random_row%0d: req_ready=%b left=%0d, required 1 and 0",
                         r, req_ready, exp_q.size());
            end
        end
        pix_ready = 1'b1;
    endtask

    // Pulses req_valid in FETCH (k=3) and DRAIN (k=16); both must be ignored.
    task automatic test_ignore();
        bit ok;
        int bad = 0;
        pix_ready = 1'b1;
        send_req(7, 1'b0, 1'b0, ok);
        for (int k = 0; k < 18; k++) begin
            req_valid = (k == 3) || (k == 16);
            req_row   = 4'd12;
            req_hflip = 1'b1;
            if (k == 16) begin
                checks++;
                if (dbg_state !== DRAIN) begin
                    errors++;
                    $display("FAIL ignore_state: got %0d, required %0d", dbg_state, DRAIN);
                end
            end
            if (req_ready !== 1'b0) bad++;
            tick();
        end
        req_valid = 1'b0;
        req_hflip = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignore_ready: req_ready high in %0d busy cycles, required 0", bad);
        end
        test_row(10, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int start;
        int n = 0;
        int bad = 0;
        pix_ready = 1'b1;
        start = pop_cnt;
        send_req(9, 1'b0, 1'b1, ok);
        while (pop_cnt - start < 7 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (pop_cnt - start != 7) begin
            errors++;
            $display("FAIL midreset_pixels: got %0d, required 7", pop_cnt - start);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if ({rom_chipselect, rom_address, rom_clken, pix_valid, pix_last, pix_data,
             busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: cs=%b addr=%h clken=%b pv=%b last=%b data=%h busy=%b rr=%b, required all 0",
                     rom_chipselect, rom_address, rom_clken, pix_valid, pix_last, pix_data,
                     busy, req_ready);
        end
        exp_q.delete();
        reset_n = 1'b1;
        tick();
        checks++;
        if ({req_ready, rom_clken} !== 2'b11) begin
            errors++;
            $display("FAIL midreset_release: rr=%b clken=%b, required 1 1", req_ready, rom_clken);
        end
        for (int k = 0; k < 6; k++) begin
            if (pix_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_stale: pix_valid high in %0d cycles, required 0", bad);
        end
        test_row(5, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_row(3, 1'b0, 1'b0);
        test_row(3, 1'b1, 1'b0);
        test_row(3, 1'b0, 1'b1);
        test_row(3, 1'b1, 1'b1);
        test_stall();
        test_random();
        test_ignore();
        test_reset_mid();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d pixels outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
